sad_match_engine: RTL and testbench

//  Downstream consumer of the 16x16 window stream from the window handler. Each valid

---
 rtl/astro_pkg.sv | 25 ++
 rtl/sad_tree.sv | 78 +++++++
 rtl/sad_match_engine.sv | 170 +++++++++++++++++
 tb/tb_sad_match_engine.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/astro_pkg.sv
// Shared pixel/window types and frame geometry for the window handler and SAD match engine.
// Also holds the match-engine FSM encoding and the per-pixel absolute-difference helper.
package astro_pkg;

    localparam int IMG_W = 80;
    localparam int IMG_H = 80;
    localparam int WIN   = 16;
    localparam int POS_W = 14;

    typedef logic [7:0]                      pixel_t;
    typedef logic [WIN-1:0][WIN-1:0][7:0]    window_t;
    typedef logic [15:0]                     sad_t;
    typedef logic [11:0]                     row_sum_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    function automatic pixel_t abs_diff(input pixel_t a, input pixel_t b);
        return (a > b) ? pixel_t'(a - b) : pixel_t'(b - a);
    endfunction

endpackage

// File: rtl/sad_tree.sv
// Three-stage SAD pipeline: per-pixel |w-t|, per-row sums, frame total.
// A valid bit and a 14-bit {y,x} position tag travel alongside each window.
module sad_tree
    import astro_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  window_t          win_i,
    input  window_t          tmpl_i,
    input  logic [POS_W-1:0] pos_i,
    output logic             valid_o,
    output sad_t             sad_o,
    output logic [POS_W-1:0] pos_o
);

    window_t                   absd_q, absd_d;
    row_sum_t [WIN-1:0]        row_q, row_d;
    sad_t                      sad_q, sad_d;
    logic [2:0]                vld_q;
    logic [2:0][POS_W-1:0]     pos_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        absd_d = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                absd_d[r][c] = abs_diff(win_i[r][c], tmpl_i[r][c]);
            end
        end
    end

    always_comb begin
        row_d = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                row_d[r] = row_d[r] + row_sum_t'(absd_q[r][c]);
            end
        end
    end

    always_comb begin
        sad_d = '0;
        for (int r = 0; r < WIN; r++) begin
            sad_d = sad_d + sad_t'(row_q[r]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[1:0], valid_i};
        end
    end

    // NOTE: the wide data stages carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (valid_i) begin
            absd_q   <= absd_d;
            pos_q[0] <= pos_i;
        end
        if (vld_q[0]) begin
            row_q    <= row_d;
            pos_q[1] <= pos_q[0];
        end
        if (vld_q[1]) begin
            sad_q    <= sad_d;
            pos_q[2] <= pos_q[1];
        end
    end

    assign valid_o = vld_q[2];
    assign sad_o   = sad_q;
    assign pos_o   = pos_q[2];

endmodule

// File: rtl/sad_match_engine.sv
// Frame-level SAD template matcher: FSM, window position counters, template register, min tracker.
// Optional MATCH_THRESH_EN adds a thresh input and a hit_count of SADs below it.
module sad_match_engine
    import astro_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        tmpl_load,
    input  window_t     tmpl_data,
    input  window_t     window_data,
    input  logic        window_ready,
`ifdef MATCH_THRESH_EN
    input  sad_t        thresh,
    output logic [12:0] hit_count,
`endif
    output logic        receive,
    output logic        busy,
    output logic        result_valid,
    output sad_t        best_sad,
    output logic [6:0]  best_x,
    output logic [6:0]  best_y
);

    localparam int         NUM_X  = IMG_W - WIN + 1;
    localparam int         NUM_Y  = IMG_H - WIN + 1;
    localparam logic [6:0] X_LAST = 7'(NUM_X - 1);
    localparam logic [6:0] Y_LAST = 7'(NUM_Y - 1);

    state_e           state_q, state_d;
    logic [6:0]       x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [1:0]       drain_cnt_q, drain_cnt_d;
    logic             result_valid_q, result_valid_d;
    window_t          tmpl_q;
    sad_t             best_sad_q, best_sad_d;
    logic [6:0]       best_x_q, best_x_d, best_y_q, best_y_d;

    logic             arm, accept, last_win;
    logic             s3_valid;
    sad_t             s3_sad;
    logic [POS_W-1:0] s3_pos;

    assign arm      = start && (state_q == ST_IDLE);
    assign accept   = window_ready && (state_q == ST_RUN);
    assign last_win = accept && (x_cnt_q == X_LAST) && (y_cnt_q == Y_LAST);

    sad_tree u_sad_tree (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (accept),
        .win_i   (window_data),
        .tmpl_i  (tmpl_q),
        .pos_i   ({y_cnt_q, x_cnt_q}),
        .valid_o (s3_valid),
        .sad_o   (s3_sad),
        .pos_o   (s3_pos)
    );

    always_comb begin
        state_d        = state_q;
        x_cnt_d        = x_cnt_q;
        y_cnt_d        = y_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        result_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    x_cnt_d = '0;
                    y_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (x_cnt_q == X_LAST) begin
                        x_cnt_d = '0;
                        y_cnt_d = y_cnt_q + 7'd1;
                    end else begin
                        x_cnt_d = x_cnt_q + 7'd1;
                    end
                end
                if (last_win) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                // The last window reaches S3 in the third drain cycle; the pulse lands with its min update.
                if (drain_cnt_q == 2'd2) begin
                    state_d        = ST_IDLE;
                    result_valid_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        best_sad_d = best_sad_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        if (arm) begin
            best_sad_d = '1;
        end else if (s3_valid && (s3_sad < best_sad_q)) begin
            // Strict compare keeps the earlier window on a tie.
            best_sad_d = s3_sad;
            best_x_d   = s3_pos[6:0];
            best_y_d   = s3_pos[13:7];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            x_cnt_q        <= '0;
            y_cnt_q        <= '0;
            drain_cnt_q    <= '0;
            result_valid_q <= 1'b0;
            tmpl_q         <= '0;
            best_sad_q     <= '1;
            best_x_q       <= '0;
            best_y_q       <= '0;
        end else begin
            state_q        <= state_d;
            x_cnt_q        <= x_cnt_d;
            y_cnt_q        <= y_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            result_valid_q <= result_valid_d;
            if (tmpl_load && (state_q == ST_IDLE)) begin
                tmpl_q <= tmpl_data;
            end
            best_sad_q     <= best_sad_d;
            best_x_q       <= best_x_d;
            best_y_q       <= best_y_d;
        end
    end

`ifdef MATCH_THRESH_EN
    logic [12:0] hit_cnt_q, hit_cnt_d;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (arm) begin
            hit_cnt_d = '0;
        end else if (s3_valid && (s3_sad < thresh)) begin
            hit_cnt_d = hit_cnt_q + 13'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_count = hit_cnt_q;
`endif

    assign receive      = accept;
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = result_valid_q;
    assign best_sad     = best_sad_q;
    assign best_x       = best_x_q;
    assign best_y       = best_y_q;

endmodule

// File: tb/tb_sad_match_engine.sv
// Self-checking bench for sad_match_engine: table-driven frames, random frames against a
// behavioural SAD/min model, reset mid-frame, and (with MATCH_THRESH_EN) the hit counter.
module tb_sad_match_engine;
    import astro_pkg::*;

    localparam int NX = IMG_W - WIN + 1;
    localparam int NY = IMG_H - WIN + 1;

    localparam int MODE_TABLE = 0;
    localparam int MODE_RAND  = 1;
    localparam int MODE_HITS  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        tmpl_load;
    window_t     tmpl_data;
    window_t     window_data;
    logic        window_ready;
    logic        receive;
    logic        busy;
    logic        result_valid;
    sad_t        best_sad;
    logic [6:0]  best_x;
    logic [6:0]  best_y;
`ifdef MATCH_THRESH_EN
    sad_t        thresh;
    logic [12:0] hit_count;
`endif

    always #5 clk = ~clk;

    sad_match_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .tmpl_load    (tmpl_load),
        .tmpl_data    (tmpl_data),
        .window_data  (window_data),
        .window_ready (window_ready),
`ifdef MATCH_THRESH_EN
        .thresh       (thresh),
        .hit_count    (hit_count),
`endif
        .receive      (receive),
        .busy         (busy),
        .result_valid (result_valid),
        .best_sad     (best_sad),
        .best_x       (best_x),
        .best_y       (best_y)
    );

    typedef struct {
        int tmpl_val;
        int bg_val;
        int sx0, sy0, sv0;
        int sx1, sy1, sv1;
        bit gaps;
        bit inject;
        int exp_sad;
        int exp_x;
        int exp_y;
    } vec_t;

    vec_t    vecs[5];
    vec_t    rnd_vec;
    window_t cur_tmpl;
    window_t model_tmpl;
    int      m_best_sad, m_best_x, m_best_y, m_hits, m_thresh;
    int      n_checks = 0;
    int      n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_sad(input window_t a, input window_t b);
        int s = 0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                int d = int'(a[r][c]) - int'(b[r][c]);
                s += (d < 0) ? -d : d;
            end
        end
        return s;
    endfunction

    function automatic bit is_hit_idx(input int idx);
        return idx == 0 || idx == 64 || idx == 1000 || idx == 2000 ||
               idx == 2112 || idx == 4160 || idx == 4224;
    endfunction

    function automatic window_t make_win(input int mode, input vec_t v, input int x, input int y, input int idx);
        window_t w;
        pixel_t  p;
        pixel_t  mask;
        w = '0;
        case (mode)
            MODE_TABLE: begin
                p = 8'(v.bg_val);
                w = {256{p}};
                if (x == v.sx0 && y == v.sy0) begin
                    p = 8'(v.sv0);
                    w = {256{p}};
                end
                if (x == v.sx1 && y == v.sy1) begin
                    p = 8'(v.sv1);
                    w = {256{p}};
                end
            end
            MODE_RAND: begin
                case ($urandom_range(0, 4))
                    0: mask = 8'h01;
                    1: mask = 8'h03;
                    2: mask = 8'h07;
                    3: mask = 8'h0F;
                    default: mask = 8'hFF;
                endcase
                for (int r = 0; r < WIN; r++) begin
                    for (int c = 0; c < WIN; c++) begin
                        w[r][c] = model_tmpl[r][c] ^ (8'($urandom) & mask);
                    end
                end
            end
            default: begin
                // Against a zero template: 50 ones gives SAD 50; 212 ones + 44 twos gives SAD 300.
                for (int i = 0; i < 256; i++) begin
                    if (is_hit_idx(idx)) w[i / 16][i % 16] = (i < 50) ? 8'd1 : 8'd0;
                    else                 w[i / 16][i % 16] = (i < 44) ? 8'd2 : 8'd1;
                end
            end
        endcase
        return w;
    endfunction

    // Runs one frame: start (optionally with template load), stream windows, then check drain timing.
    // stop_after >= 0 abandons the frame after that many windows (no result wait).
    task automatic run_frame(input bit do_load, input int mode, input vec_t v, input int stop_after);
        int      idx = 0;
        int      rx_bad = 0;
        int      busy_bad = 0;
        int      lat;
        int      s;
        window_t w;
        @(negedge clk);
        start        = 1'b1;
        tmpl_load    = do_load;
        tmpl_data    = cur_tmpl;
        window_ready = 1'b0;
        if (do_load) model_tmpl = cur_tmpl;
        m_best_sad = 65535;
        m_best_x   = 0;
        m_best_y   = 0;
        m_hits     = 0;
        for (int y = 0; y < NY; y++) begin
            for (int x = 0; x < NX; x++) begin
                if (v.gaps && $urandom_range(0, 7) == 0) begin
                    @(negedge clk);
                    start        = 1'b0;
                    tmpl_load    = 1'b0;
                    window_ready = 1'b0;
                    #1;
                    if (receive) rx_bad++;
                end
                @(negedge clk);
                start     = 1'b0;
                tmpl_load = 1'b0;
                if (stop_after >= 0 && idx == stop_after) begin
                    window_ready = 1'b0;
                    check("receive_stream_partial", rx_bad, 0);
                    return;
                end
                w            = make_win(mode, v, x, y, idx);
                window_data  = w;
                window_ready = 1'b1;
                if (v.inject && idx == 100) begin
                    start     = 1'b1;
                    tmpl_load = 1'b1;
                    tmpl_data = '0;
                end
                #1;
                if (!receive) rx_bad++;
                s = ref_sad(w, model_tmpl);
                if (s < m_best_sad) begin
                    m_best_sad = s;
                    m_best_x   = x;
                    m_best_y   = y;
                end
                if (s < m_thresh) m_hits++;
                idx++;
            end
        end
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start        = 1'b0;
            tmpl_load    = 1'b0;
            window_ready = 1'b0;
            if (result_valid) begin
                lat = n;
                break;
            end
            if (!busy) busy_bad++;
        end
        check("receive_stream", rx_bad, 0);
        check("busy_during_drain", busy_bad, 0);
        check("result_valid_latency", lat, 4);
        check("busy_at_result", busy, 0);
        @(negedge clk);
        check("result_valid_one_cycle", result_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_receive"},      receive, 0);
        check({tag, "_busy"},         busy, 0);
        check({tag, "_result_valid"}, result_valid, 0);
        check({tag, "_best_sad"},     best_sad, 16'hFFFF);
        check({tag, "_best_x"},       best_x, 0);
        check({tag, "_best_y"},       best_y, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        pixel_t p;
        int     rv_seen;

        vecs[0] = '{8'h10, 8'h00, 20, 33, 8'h10, 20, 33, 8'h10, 1'b0, 1'b1, 0,     20, 33};
        vecs[1] = '{8'h00, 8'hFF,  0,  0, 8'hFF,  0,  0, 8'hFF, 1'b1, 1'b0, 65280,  0,  0};
        vecs[2] = '{8'h40, 8'h48, 64, 64, 8'h47, 64, 64, 8'h47, 1'b0, 1'b0, 1792,  64, 64};
        vecs[3] = '{8'h80, 8'h70,  0,  0, 8'h7F,  5,  5, 8'h81, 1'b1, 1'b0, 256,    0,  0};
        vecs[4] = '{8'h80, 8'h70,  5,  5, 8'h81, 40,  3, 8'h7F, 1'b0, 1'b0, 256,   40,  3};
        rnd_vec = '{default: 0};
        rnd_vec.sx0 = 99; rnd_vec.sy0 = 99; rnd_vec.sx1 = 99; rnd_vec.sy1 = 99;

        rst_n        = 1'b0;
        start        = 1'b0;
        tmpl_load    = 1'b0;
        tmpl_data    = '0;
        window_data  = '0;
        window_ready = 1'b0;
        m_thresh     = 0;
`ifdef MATCH_THRESH_EN
        thresh       = 16'd2000;
        m_thresh     = 2000;
`endif
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            p        = 8'(vecs[i].tmpl_val);
            cur_tmpl = {256{p}};
            run_frame(1'b1, MODE_TABLE, vecs[i], -1);
            check($sformatf("vec%0d_best_sad", i), best_sad, vecs[i].exp_sad);
            check($sformatf("vec%0d_best_x", i),   best_x,   vecs[i].exp_x);
            check($sformatf("vec%0d_best_y", i),   best_y,   vecs[i].exp_y);
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            window_ready = 1'b1;
            window_data  = '0;
            #1;
            check("idle_window_receive", receive, 0);
            check("idle_window_busy", busy, 0);
        end
        @(negedge clk);
        window_ready = 1'b0;
        check("best_sad_held", best_sad, vecs[4].exp_sad);
        check("best_x_held", best_x, vecs[4].exp_x);

        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                cur_tmpl[r][c] = 8'($urandom);
        rnd_vec.gaps = 1'b1;
        run_frame(1'b1, MODE_RAND, rnd_vec, -1);
        check("rand_best_sad", best_sad, m_best_sad);
        check("rand_best_x", best_x, m_best_x);
        check("rand_best_y", best_y, m_best_y);
`ifdef MATCH_THRESH_EN
        check("rand_hit_count", hit_count, m_hits);
`endif

        rnd_vec.gaps = 1'b0;
        run_frame(1'b1, MODE_RAND, rnd_vec, 1000);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        @(negedge clk);
        rst_n = 1'b1;
        rv_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (result_valid || busy) rv_seen++;
        end
        check("no_result_after_reset", rv_seen, 0);

        model_tmpl = '0;
        run_frame(1'b0, MODE_RAND, rnd_vec, -1);
        check("post_reset_best_sad", best_sad, m_best_sad);
        check("post_reset_best_x", best_x, m_best_x);
        check("post_reset_best_y", best_y, m_best_y);

`ifdef MATCH_THRESH_EN
        thresh   = 16'd100;
        m_thresh = 100;
        cur_tmpl = '0;
        run_frame(1'b1, MODE_HITS, rnd_vec, -1);
        check("thresh_hit_count", hit_count, 7);
        check("thresh_best_sad", best_sad, 50);
        check("thresh_best_x", best_x, 0);
        check("thresh_best_y", best_y, 0);
        repeat (3) @(negedge clk);
        check("thresh_hit_count_held", hit_count, 7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
